// File: rtl/alu_display_driver_pkg.sv
// Shared definitions for the ALU result display driver: scan states,
// active-low seven-segment codes and anode patterns.
package alu_display_driver_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_e;

    // Segment order {g,f,e,d,c,b,a}, active low; index 15 is leftmost.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = '{
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    function automatic logic [3:0] an_for_state(input scan_state_e st);
        logic [3:0] an_v;
        an_v = AN_OFF;
        an_v[st] = 1'b0;
        return an_v;
    endfunction

endpackage

// File: rtl/alu_display_driver_hex_seg_decoder.sv
// Nibble to active-low seven-segment decode, shared table from the package.
module hex_seg_decoder
    import alu_display_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/alu_display_driver.sv
// Four-digit multiplexed display of an ALU result (Y, op code) with frame-synchronous update.
// Optional SIGNED_DISP_EN shows Y as two's-complement with a leading minus on digit 2.
//
// state | meaning
// DIG0  | low nibble of displayed Y (magnitude when signed)
// DIG1  | high nibble of displayed Y (magnitude when signed)
// DIG2  | blank, or minus sign for negative Y when signed
// DIG3  | displayed op code; its last cycle is the frame boundary
module alu_display_driver
    import alu_display_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] y_in,
    input  logic [3:0] op_in,
    input  logic       load,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       pending,
    output logic       frame_done
);

    localparam int unsigned        CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    scan_state_e      state_q, state_d;
    logic             run_q;
    logic [7:0]       shadow_y_q, shadow_y_d;
    logic [3:0]       shadow_op_q, shadow_op_d;
    logic [7:0]       disp_y_q, disp_y_d;
    logic [3:0]       disp_op_q, disp_op_d;
    logic             pending_q, pending_d;

    logic             cnt_wrap;
    logic             boundary;
    logic [7:0]       y_show;
    logic             y_neg;
    logic [3:0]       nibble;
    logic [6:0]       dec_seg;
    logic [6:0]       digit_seg;

    assign cnt_wrap = (cnt_q == CNT_MAX);
    assign boundary = run_q && cnt_wrap && (state_q == DIG3);

    always_comb begin
        cnt_d       = cnt_q;
        state_d     = state_q;
        shadow_y_d  = shadow_y_q;
        shadow_op_d = shadow_op_q;
        disp_y_d    = disp_y_q;
        disp_op_d   = disp_op_q;
        pending_d   = pending_q;

        if (run_q) begin
            if (cnt_wrap) begin
                cnt_d   = '0;
                state_d = scan_state_e'(state_q + 2'd1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A load landing on the boundary bypasses the shadow so it is not lost for a frame.
        if (boundary) begin
            disp_y_d  = load ? y_in  : shadow_y_q;
            disp_op_d = load ? op_in : shadow_op_q;
            pending_d = 1'b0;
            if (load) begin
                shadow_y_d  = y_in;
                shadow_op_d = op_in;
            end
        end else if (load) begin
            shadow_y_d  = y_in;
            shadow_op_d = op_in;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            state_q     <= DIG0;
            run_q       <= 1'b0;
            shadow_y_q  <= '0;
            shadow_op_q <= '0;
            disp_y_q    <= '0;
            disp_op_q   <= '0;
            pending_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            run_q       <= 1'b1;
            shadow_y_q  <= shadow_y_d;
            shadow_op_q <= shadow_op_d;
            disp_y_q    <= disp_y_d;
            disp_op_q   <= disp_op_d;
            pending_q   <= pending_d;
        end
    end

`ifdef SIGNED_DISP_EN
    // 0x80 negates to itself, which reads correctly as magnitude 80.
    assign y_neg  = disp_y_q[7];
    assign y_show = y_neg ? (~disp_y_q + 8'd1) : disp_y_q;
`else
    assign y_neg  = 1'b0;
    assign y_show = disp_y_q;
`endif

    always_comb begin
        nibble = 4'h0;
        case (state_q)
            DIG0:    nibble = y_show[3:0];
            DIG1:    nibble = y_show[7:4];
            DIG3:    nibble = disp_op_q;
            default: nibble = 4'h0;
        endcase
    end

    hex_seg_decoder u_hex_seg_decoder (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    always_comb begin
        digit_seg = dec_seg;
        if (state_q == DIG2) begin
            digit_seg = y_neg ? SEG_MINUS : SEG_BLANK;
        end
    end

    // run_q keeps the display dark through reset and lights DIG0 the cycle after release.
    assign seg        = (blank || !run_q) ? SEG_BLANK : digit_seg;
    assign an         = (blank || !run_q) ? AN_OFF    : an_for_state(state_q);
    assign pending    = pending_q;
    assign frame_done = boundary;

endmodule

// File: doc/alu_display_driver.md
ALU_DISPLAY_DRIVER -- requirements
Module: alu_display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the number of clk cycles each digit is displayed (minimum 2).
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-004 y_in  input  8  SHALL carry the ALU result to display.
REQ-005 op_in  input  4  SHALL carry the operation code to display.
REQ-006 load  input  1  SHALL be a one-cycle request to capture y_in/op_in.
REQ-007 blank  input  1  SHALL force all digits off while high.
REQ-008 seg  output  7  SHALL drive active-low segments {g,f,e,d,c,b,a}.
REQ-009 an  output  4  SHALL drive active-low one-hot digit anodes.
REQ-010 pending  output  1  SHALL be high while a captured value awaits display.
REQ-011 frame_done  output  1  SHALL pulse for one cycle at each frame boundary.

Function
REQ-012 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; each wrap SHALL advance the scan state.
REQ-013 Scan FSM states DIG0->DIG1->DIG2->DIG3->DIG0 SHALL drive an = 1110, 1101, 1011, 0111 respectively.
REQ-014 DIG0/DIG1 SHALL show the low/high hex nibble of the displayed Y; DIG3 SHALL show the displayed op code in hex.
REQ-015 DIG2 SHALL be blank (seg = 1111111) unless REQ-024 applies.
REQ-016 Hex decode SHALL be standard: e.g. 0=1000000, 1=1111001, 2=0100100, 3=0110000, 5=0010010, A=0001000.
REQ-017 load high SHALL capture y_in/op_in into the shadow registers and set pending; the last load in a frame wins.
REQ-018 The frame boundary is the DIG3->DIG0 transition cycle; at it the shadow values SHALL transfer to the display registers, pending SHALL clear, and frame_done SHALL be 1.
REQ-019 A load in the boundary cycle SHALL transfer y_in/op_in directly to the display registers, leaving pending at 0.
REQ-020 The display registers SHALL never change except at a frame boundary (no tearing).
REQ-021 blank high SHALL force an = 1111 and seg = 1111111 combinationally; counter, FSM and load handling continue.
REQ-022 seg and an SHALL be registered or glitch-free decodes of registered state.

Reset
REQ-023 While reset = 0: counter = 0, state = DIG0, shadow/display registers = 0, pending = 0, frame_done = 0, an = 1111, seg = 1111111; first lit digit SHALL appear the cycle after release.

Configuration
REQ-024 With SIGNED_DISP_EN defined, displayed Y SHALL be two's-complement: if Y[7]=1, DIG2 SHALL show '-' (0111111) and DIG1/DIG0 the magnitude (0x80 shows -80); without it, Y SHALL be unsigned hex and DIG2 blank.

Structure
REQ-025 A shared package SHALL hold the scan-state enum, the 16-entry hex segment table, SEG_BLANK and SEG_MINUS constants.
REQ-026 Segment decoding SHALL be one sub-module, hex_seg_decoder (4-bit nibble in, 7-bit active-low seg out).

Verification (REFRESH_DIV = 4, frame = 16 cycles)
REQ-027 Release reset, no load -> an cycles 1110,1101,1011,0111 four cycles each; seg 1000000 on DIG0/1/3, 1111111 on DIG2.
REQ-028 load y=0xA5 op=0x3 mid-frame -> pending=1, display unchanged; after frame_done: DIG0 0010010, DIG1 0001000, DIG3 0110000, pending=0.
REQ-029 loads 0x11 then 0x22 in same frame -> next frame shows 22, one frame_done pulse.
REQ-030 load y=0x12 on boundary cycle -> next frame shows 12, pending stays 0.
REQ-031 y=0xFE: with SIGNED_DISP_EN DIG2 0111111, DIG1 1000000, DIG0 0100100; without, DIG1/DIG0 show F/E, DIG2 blank.
REQ-032 reset=0 mid-frame with pending=1 -> next cycle an=1111, seg=1111111, pending=0, display value 0.
